can_rx_fifo: RTL and testbench

Host-side reader for frames produced by the CAN controller's receive path. It consumes the controller's single-cycle rx_valid/rx_id/rx_dlc/rx_data frame strobe and applies an 11-bit code/mask acceptance filter. Accepted frames are stored in a DEPTH-entry FIFO and presented to the host through a first-word-fall-through valid/ready read port. Overflow status and a drop counter are maintained.

---
 rtl/can_rx_fifo.sv | 189 ++++++++++++++++++
 tb/tb_can_rx_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/can_rx_fifo.sv
// rtl/can_rx_fifo.sv - CAN receive frame FIFO with acceptance filter and FWFT read port
//
// Purpose:
//   Takes completed frames from the CAN controller receive path, filters them
//   with an 11-bit code/mask acceptance filter, stores accepted frames in a
//   DEPTH-entry FIFO and presents the head entry to the host through a
//   first-word-fall-through valid/ready port. Frames arriving while the FIFO
//   is full are dropped and recorded in a sticky overflow flag and a
//   saturating drop counter.
//
// Optional feature macro: CAN_RX_TIMESTAMP_EN
//   Defined     - a 16-bit free-running counter is stamped into each entry on
//                 push and the head entry's stamp drives rd_timestamp.
//   Not defined - no counter or stamp storage; rd_timestamp is tied to zero.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   rx_valid/rx_id/rx_dlc/rx_data  single-cycle frame strobe from the controller
//   filt_en/filt_code/filt_mask acceptance filter control (mask 1 = compare)
//   rd_valid/rd_ready           host read handshake (FWFT)
//   rd_id/rd_dlc/rd_data        head entry fields (payload sanitised by DLC)
//   rd_timestamp                head entry timestamp (zero when feature off)
//   fifo_count                  number of stored entries, 0..DEPTH
//   overflow/drop_count         sticky drop flag and saturating drop counter
//   clr_overflow                one-cycle clear of overflow and drop_count

module can_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_valid,
    input  logic [10:0]   rx_id,
    input  logic [3:0]    rx_dlc,
    input  logic [63:0]   rx_data,
    input  logic          filt_en,
    input  logic [10:0]   filt_code,
    input  logic [10:0]   filt_mask,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [10:0]   rd_id,
    output logic [3:0]    rd_dlc,
    output logic [63:0]   rd_data,
    output logic [15:0]   rd_timestamp,
    output logic [AW:0]   fifo_count,
    output logic          overflow,
    output logic [7:0]    drop_count,
    input  logic          clr_overflow
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    // Frame storage; contents are intentionally not reset.
    logic [10:0] mem_id   [DEPTH];
    logic [3:0]  mem_dlc  [DEPTH];
    logic [63:0] mem_data [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          accept;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;
    logic [3:0]    n_bytes;
    logic [63:0]   data_clean;

    // ------------------------------------------------------------------
    // Acceptance filter and handshake decode
    // ------------------------------------------------------------------
    assign accept = rx_valid & (~filt_en | (((rx_id ^ filt_code) & filt_mask) == 11'd0));

    // Fullness uses the registered count, so a same-cycle pop cannot make
    // room for an incoming frame.
    assign full   = (count == FULL_CNT);
    assign push   = accept & ~full;
    assign drop   = accept & full;
    assign pop    = rd_valid & rd_ready;

    // ------------------------------------------------------------------
    // Payload sanitising: bytes beyond min(DLC, 8) are zeroed. Byte 0 is
    // the most significant byte of rx_data.
    // ------------------------------------------------------------------
    always_comb begin
        n_bytes    = (rx_dlc > 4'd8) ? 4'd8 : rx_dlc;
        data_clean = 64'd0;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < n_bytes) begin
                data_clean[63-8*k -: 8] = rx_data[63-8*k -: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage write
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_ptr]   <= rx_id;
            mem_dlc[wr_ptr]  <= rx_dlc;
            mem_data[wr_ptr] <= data_clean;
        end
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Overflow status. A drop in the same cycle as a clear wins, leaving
    // the counter at one to record that drop.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_overflow) begin
                drop_count <= 8'd1;
            end else if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end else if (clr_overflow) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end
    end

    // ------------------------------------------------------------------
    // Optional receive timestamp
    // ------------------------------------------------------------------
`ifdef CAN_RX_TIMESTAMP_EN
    logic [15:0] ts_cnt;
    logic [15:0] mem_ts [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt <= 16'd0;
        end else begin
            ts_cnt <= ts_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_ts[wr_ptr] <= ts_cnt;
        end
    end

    assign rd_timestamp = mem_ts[rd_ptr];
`else
    assign rd_timestamp = 16'h0000;
`endif

    // ------------------------------------------------------------------
    // First-word-fall-through read port
    // ------------------------------------------------------------------
    assign rd_valid   = (count != '0);
    assign rd_id      = mem_id[rd_ptr];
    assign rd_dlc     = mem_dlc[rd_ptr];
    assign rd_data    = mem_data[rd_ptr];
    assign fifo_count = count;

endmodule

// File: tb/tb_can_rx_fifo.sv
// tb/tb_can_rx_fifo.sv - self-checking bench for can_rx_fifo

module tb_can_rx_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [10:0] rx_id = '0;
    logic [3:0]  rx_dlc = '0;
    logic [63:0] rx_data = '0;
    logic        filt_en = 1'b0;
    logic [10:0] filt_code = '0;
    logic [10:0] filt_mask = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [10:0] rd_id;
    logic [3:0]  rd_dlc;
    logic [63:0] rd_data;
    logic [15:0] rd_timestamp;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        clr_overflow = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;

    can_rx_fifo #(.DEPTH(8), .AW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_valid(rx_valid), .rx_id(rx_id), .rx_dlc(rx_dlc), .rx_data(rx_data),
        .filt_en(filt_en), .filt_code(filt_code), .filt_mask(filt_mask),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_id(rd_id), .rd_dlc(rd_dlc), .rd_data(rd_data),
        .rd_timestamp(rd_timestamp), .fifo_count(fifo_count),
        .overflow(overflow), .drop_count(drop_count), .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [10:0] id;
        logic [3:0]  dlc;
        logic [63:0] data;
        logic        fe;
        logic [10:0] code;
        logic [10:0] mask;
        logic        rdy;
        logic        ev;
        logic [10:0] eid;
        logic [3:0]  edlc;
        logic [63:0] edata;
        logic [3:0]  ecnt;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // One clock: drive inputs after the previous edge, then sample 1 time unit after the edge.
    task automatic cyc(input logic v, input logic [10:0] id, input logic [3:0] dlc,
                       input logic [63:0] data, input logic rdy, input logic clr);
        rx_valid = v; rx_id = id; rx_dlc = dlc; rx_data = data;
        rd_ready = rdy; clr_overflow = clr;
        @(posedge clk);
        #1;
        rx_valid = 1'b0; rd_ready = 1'b0; clr_overflow = 1'b0;
    endtask

    function automatic vec_t mk(logic v, logic [10:0] id, logic [3:0] dlc, logic [63:0] data,
                                logic fe, logic [10:0] code, logic [10:0] mask, logic rdy,
                                logic ev, logic [10:0] eid, logic [3:0] edlc,
                                logic [63:0] edata, logic [3:0] ecnt);
        vec_t r;
        r.v = v; r.id = id; r.dlc = dlc; r.data = data; r.fe = fe; r.code = code;
        r.mask = mask; r.rdy = rdy; r.ev = ev; r.eid = eid; r.edlc = edlc;
        r.edata = edata; r.ecnt = ecnt;
        return r;
    endfunction

    logic [15:0] ts_a;

    initial begin
        // Test 1: unfiltered frame, DLC 2 sanitising, then pop
        vt[0]  = mk(1, 11'h123, 4'd2, 64'hAABBCCDDEEFF1122, 0, 11'h000, 11'h000, 0,
                    1, 11'h123, 4'd2, 64'hAABB000000000000, 4'd1);
        vt[1]  = mk(0, 11'h000, 4'd0, 64'h0, 0, 11'h000, 11'h000, 1,
                    0, 11'h000, 4'd0, 64'h0, 4'd0);
        // Test 2: code/mask filter
        vt[2]  = mk(1, 11'h12F, 4'd8, 64'h0102030405060708, 1, 11'h120, 11'h7F0, 0,
                    1, 11'h12F, 4'd8, 64'h0102030405060708, 4'd1);
        vt[3]  = mk(1, 11'h130, 4'd8, 64'h1111111111111111, 1, 11'h120, 11'h7F0, 0,
                    1, 11'h12F, 4'd8, 64'h0102030405060708, 4'd1);
        vt[4]  = mk(1, 11'h7FF, 4'd0, 64'hFFFFFFFFFFFFFFFF, 1, 11'h120, 11'h000, 0,
                    1, 11'h12F, 4'd8, 64'h0102030405060708, 4'd2);
        vt[5]  = mk(0, 11'h000, 4'd0, 64'h0, 1, 11'h120, 11'h000, 1,
                    1, 11'h7FF, 4'd0, 64'h0, 4'd1);
        vt[6]  = mk(0, 11'h000, 4'd0, 64'h0, 1, 11'h120, 11'h000, 1,
                    0, 11'h000, 4'd0, 64'h0, 4'd0);
        // DLC 5 sanitising, simultaneous push+pop, pop of empty FIFO
        vt[7]  = mk(1, 11'h055, 4'd5, 64'h1122334455667788, 0, 11'h000, 11'h7FF, 0,
                    1, 11'h055, 4'd5, 64'h1122334455000000, 4'd1);
        vt[8]  = mk(1, 11'h066, 4'd1, 64'hABCDEF0123456789, 0, 11'h000, 11'h7FF, 1,
                    1, 11'h066, 4'd1, 64'hAB00000000000000, 4'd1);
        vt[9]  = mk(0, 11'h000, 4'd0, 64'h0, 0, 11'h000, 11'h000, 1,
                    0, 11'h000, 4'd0, 64'h0, 4'd0);
        vt[10] = mk(0, 11'h000, 4'd0, 64'h0, 0, 11'h000, 11'h000, 1,
                    0, 11'h000, 4'd0, 64'h0, 4'd0);

        // Reset state
        #12;
        chk("reset_rd_valid", 64'(rd_valid), 64'd0);
        chk("reset_count", 64'(fifo_count), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        chk("reset_drop_count", 64'(drop_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            filt_en = vt[i].fe; filt_code = vt[i].code; filt_mask = vt[i].mask;
            cyc(vt[i].v, vt[i].id, vt[i].dlc, vt[i].data, vt[i].rdy, 1'b0);
            chk($sformatf("vec%0d_valid", i), 64'(rd_valid), 64'(vt[i].ev));
            chk($sformatf("vec%0d_count", i), 64'(fifo_count), 64'(vt[i].ecnt));
            if (vt[i].ev) begin
                chk($sformatf("vec%0d_id", i), 64'(rd_id), 64'(vt[i].eid));
                chk($sformatf("vec%0d_dlc", i), 64'(rd_dlc), 64'(vt[i].edlc));
                chk($sformatf("vec%0d_data", i), rd_data, vt[i].edata);
            end
        end
        filt_en = 1'b0;

        // Test 3: fill, overflow by 3, drain in order
        for (int i = 1; i <= 11; i++) cyc(1, 11'(i), 4'd8, {8{8'(i)}}, 0, 0);
        chk("fill_count", 64'(fifo_count), 64'd8);
        chk("fill_overflow", 64'(overflow), 64'd1);
        chk("fill_drop_count", 64'(drop_count), 64'd3);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("drain_id%0d", i), 64'(rd_id), 64'(i));
            cyc(0, 0, 0, 0, 1, 0);
        end
        chk("drain_count", 64'(fifo_count), 64'd0);
        chk("drain_valid", 64'(rd_valid), 64'd0);

        // Test 4: pop does not rescue a frame arriving at full; clear vs drop
        cyc(0, 0, 0, 0, 0, 1);
        chk("clr_overflow", 64'(overflow), 64'd0);
        chk("clr_drop_count", 64'(drop_count), 64'd0);
        for (int i = 0; i < 8; i++) cyc(1, 11'h10 + 11'(i), 4'd8, 64'h0, 0, 0);
        cyc(1, 11'h3AA, 4'd8, 64'h0, 1, 0);
        chk("fullpop_count", 64'(fifo_count), 64'd7);
        chk("fullpop_drop_count", 64'(drop_count), 64'd1);
        chk("fullpop_head", 64'(rd_id), 64'h11);
        cyc(1, 11'h18, 4'd8, 64'h0, 0, 0);
        chk("refill_count", 64'(fifo_count), 64'd8);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 11'h3BB, 4'd8, 64'h0, 0, 0);
        cyc(1, 11'h3CC, 4'd8, 64'h0, 0, 1);
        chk("clrdrop_overflow", 64'(overflow), 64'd1);
        chk("clrdrop_drop_count", 64'(drop_count), 64'd1);
        for (int i = 0; i < 260; i++) cyc(1, 11'h3DD, 4'd8, 64'h0, 0, 0);
        chk("drop_saturate", 64'(drop_count), 64'd255);

        // Test 6: asynchronous reset with 5 entries stored
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0);
        chk("pre_reset_count", 64'(fifo_count), 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(rd_valid), 64'd0);
        chk("async_rst_count", 64'(fifo_count), 64'd0);
        chk("async_rst_overflow", 64'(overflow), 64'd0);
        chk("async_rst_drop_count", 64'(drop_count), 64'd0);
        cyc(1, 11'h444, 4'd8, 64'h0, 0, 0);
        chk("rx_ignored_in_reset", 64'(fifo_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 5: 20 frames of continuous push+pop across pointer wrap
        cyc(1, 11'h200, 4'd8, {8{8'h00}}, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            cyc(1, 11'h200 + 11'(i), (i == 10) ? 4'd12 : 4'd8, {8{8'(i)}}, 1, 0);
            chk($sformatf("stream%0d_count", i), 64'(fifo_count), 64'd1);
            chk($sformatf("stream%0d_id", i), 64'(rd_id), 64'(11'h200 + 11'(i)));
            if (i == 10) begin
                chk("dlc12_dlc", 64'(rd_dlc), 64'd12);
                chk("dlc12_data", rd_data, 64'h0A0A0A0A0A0A0A0A);
            end
        end
        cyc(0, 0, 0, 0, 1, 0);
        chk("stream_empty", 64'(fifo_count), 64'd0);

        // Timestamp: two pushes 10 cycles apart
        cyc(1, 11'h500, 4'd0, 64'h0, 0, 0);
        for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 11'h501, 4'd0, 64'h0, 0, 0);
        ts_a = rd_timestamp;
        cyc(0, 0, 0, 0, 1, 0);
        chk("ts_second_head", 64'(rd_id), 64'h501);
`ifdef CAN_RX_TIMESTAMP_EN
        chk("ts_delta", 64'(16'(rd_timestamp - ts_a)), 64'd10);
`else
        chk("ts_tied_a", 64'(ts_a), 64'd0);
        chk("ts_tied_b", 64'(rd_timestamp), 64'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
